alu_exec_control: RTL and testbench
===================================

// Module: alu_exec_control
// PURPOSE
// - Registered, handshaked ALU control stage between decode and execute; next generation of the combinational ALU-function decoder.
// - Maps ALUOp + instruction funct fields to an FN_W-bit ALU function code, holds it under valid/ready backpressure.
// - Adds M-extension support: MUL/DIV ops occupy the stage for MUL_LAT/DIV_LAT cycles and stall upstream via in_ready.
// PARAMETERS
// - FN_W     6   width of alu_fn (>=6)
// - OP_W     3   width of alu_op
// - MUL_LAT  2   cycles a MUL-class op occupies the stage (>=1)
// - DIV_LAT  32  cycles a DIV/REM-class op occupies the stage (>=1)
// PORTS
// - clk          in   1      clock, rising edge
// - rst_n        in   1      asynchronous active-low reset
// - flush        in   1      synchronous kill of any held/in-flight op
// - in_valid     in   1      decode offers instruction/alu_op
// - in_ready     out  1      stage accepts this cycle
// - instruction  in   32     full instruction word
// - alu_op       in   OP_W   ALU operation class from main control
// - out_valid    out  1      alu_fn/is_multi valid to execute
// - out_ready    in   1      execute consumes this cycle
// - alu_fn       out  FN_W   ALU function code
// - is_multi     out  1      op was MUL/DIV class
// - busy         out  1      stage in MULTI
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; in_ready=0 while rst_n low, 1 from first clk after release; out_valid=0, alu_fn=0, is_multi=0, busy=0.
// - Decode (alu_op): 000 ADD, 001 SUB, 011 AND, 100 OR, 101 XOR, 110 SLT, 010 R-type, 111 M-type; others -> ADD.
// - R-type: fn from {instr[30],instr[14:12]} via package table (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND); unlisted -> ADD.
// - M-type (instr[31:25]==7'b0000001): fn=FN_MUL_BASE+instr[14:12]; is_multi=1; instr[14]=0 -> MUL_LAT, 1 -> DIV_LAT.
// - M-type with wrong funct7: single-cycle ADD, is_multi=0.
// - Upper alu_fn bits above bit 5 zero-filled.
// - States: IDLE, MULTI, HOLD.
// - IDLE: in_ready=1. Accept (in_valid) registers alu_fn/is_multi.
//     single-cycle -> HOLD, out_valid=1 next cycle (latency 1).
//     multi -> MULTI, cnt=LAT-1.
// - MULTI: in_ready=0, busy=1, out_valid=0; cnt decrements each cycle; cnt==0 -> HOLD (out_valid after LAT+1 cycles from accept).
// - HOLD: out_valid=1, alu_fn/is_multi stable until out_ready.
//     out_ready & in_valid: back-to-back accept same cycle (in_ready=out_ready in HOLD).
//     out_ready & !in_valid: -> IDLE.
// - Throughput: one single-cycle op per clock when out_ready held high.
// - flush (priority over all): next state IDLE, out_valid=0, busy=0, counter cleared; in_valid ignored that cycle.
// - Reset mid-MULTI: immediate abort, outputs to reset values, no out_valid for aborted op.
// - Counter width $clog2(max(MUL_LAT,DIV_LAT)+1); no wrap: loads only on accept.
// - Outputs registered; no combinational path in_valid->out_valid; in_ready depends only on state and out_ready.
// STRUCTURE
// - Package alu_ctrl_pkg: ALUOp encodings, FN_* codes (ADD=0,SUB=1,AND=2,SLL=3,OR=4,SLTU=5,XOR=6,SRL=7,SRA=8,SLT=11,FN_MUL_BASE=16), state enum.
// - Package also holds decode function alu_fn_decode(instr,alu_op) returning {is_multi,is_div,fn}.
// - One sub-module natural: alu_fn_decode_comb (pure combinational decode) so it is reusable by the hazard unit; FSM+counter stay in top.
// TESTING
// - Reset: hold rst_n=0 mid-stream -> out_valid=0, alu_fn=0, in_ready=0; release -> in_ready=1 next clk.
// - alu_op=110, out_ready=1 -> alu_fn=6'h0B, out_valid exactly 1 cycle after accept.
// - Back-to-back R-type ADD/SUB/SRA (instr[30],funct3 = 0/000,1/000,1/101), out_ready=1 -> fn 0,1,8 on consecutive cycles.
// - MUL (funct7=0000001,funct3=000), MUL_LAT=2 -> busy 2 cycles, in_ready=0, out_valid at accept+3, fn=16, is_multi=1.
// - DIV (funct3=100), DIV_LAT=32 -> out_valid at accept+33, fn=20.
// - Backpressure: out_ready=0 for 5 cycles in HOLD -> alu_fn stable, in_ready=0; new op accepted same cycle out_ready rises.
// - flush at MULTI cycle 10 of DIV -> IDLE next cycle, no out_valid; next ADD completes normally.
// - funct7=0100000 with alu_op=111 -> fn=0, is_multi=0, latency 1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU-control encodings, FSM state type and the ALUOp/funct -> function-code decode.
// The decode is a plain function so other stages (e.g. hazard detection) can reuse it.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_SLT   = 3'b110;
  localparam logic [2:0] OP_MTYPE = 3'b111;

  localparam logic [5:0] FN_ADD      = 6'd0;
  localparam logic [5:0] FN_SUB      = 6'd1;
  localparam logic [5:0] FN_AND      = 6'd2;
  localparam logic [5:0] FN_SLL      = 6'd3;
  localparam logic [5:0] FN_OR       = 6'd4;
  localparam logic [5:0] FN_SLTU     = 6'd5;
  localparam logic [5:0] FN_XOR      = 6'd6;
  localparam logic [5:0] FN_SRL      = 6'd7;
  localparam logic [5:0] FN_SRA      = 6'd8;
  localparam logic [5:0] FN_SLT      = 6'd11;
  localparam logic [5:0] FN_MUL_BASE = 6'd16;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULTI = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic       is_multi;
    logic       is_div;
    logic [5:0] fn;
  } dec_t;

  function automatic dec_t alu_fn_decode(input logic [31:0] instr, input logic [2:0] alu_op);
    dec_t d;
    d = '0;
    d.fn = FN_ADD;
    case (alu_op)
      OP_SUB: d.fn = FN_SUB;
      OP_AND: d.fn = FN_AND;
      OP_OR:  d.fn = FN_OR;
      OP_XOR: d.fn = FN_XOR;
      OP_SLT: d.fn = FN_SLT;
      OP_RTYPE: begin
        case ({instr[30], instr[14:12]})
          4'b0000: d.fn = FN_ADD;
          4'b1000: d.fn = FN_SUB;
          4'b0001: d.fn = FN_SLL;
          4'b0010: d.fn = FN_SLT;
          4'b0011: d.fn = FN_SLTU;
          4'b0100: d.fn = FN_XOR;
          4'b0101: d.fn = FN_SRL;
          4'b1101: d.fn = FN_SRA;
          4'b0110: d.fn = FN_OR;
          4'b0111: d.fn = FN_AND;
          default: d.fn = FN_ADD;
        endcase
      end
      OP_MTYPE: begin
        // A wrong funct7 under the M opcode class degrades to a plain single-cycle ADD.
        if (instr[31:25] == FUNCT7_M) begin
          d.is_multi = 1'b1;
          d.is_div   = instr[14];
          d.fn       = FN_MUL_BASE + {3'b000, instr[14:12]};
        end
      end
      default: d.fn = FN_ADD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_exec_control_dec.sv
// Pure combinational ALU-function decode, wrapped as a module for reuse outside the control stage.
module alu_exec_control_dec
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] instruction,
  input  logic [2:0]  alu_op,
  output logic [5:0]  fn,
  output logic        is_multi,
  output logic        is_div
);

  dec_t dec;

  assign dec      = alu_fn_decode(instruction, alu_op);
  assign fn       = dec.fn;
  assign is_multi = dec.is_multi;
  assign is_div   = dec.is_div;

endmodule

// File: rtl/alu_exec_control.sv
// Registered ALU control stage: decodes ALUOp/funct into alu_fn and holds it under valid/ready,
// stalling upstream for MUL_LAT/DIV_LAT cycles on M-extension ops.
module alu_exec_control
  import alu_ctrl_pkg::*;
#(
  parameter int FN_W    = 6,
  parameter int OP_W    = 3,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [OP_W-1:0] alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FN_W-1:0] alu_fn,
  output logic            is_multi,
  output logic            busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holding valid keeps its payload stable until that edge.
  state_t           state;
  logic             started;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       dec_fn;
  logic             dec_multi;
  logic             dec_div;
  logic             accept;

  alu_exec_control_dec u_dec (
    .instruction (instruction),
    .alu_op      (alu_op[2:0]),
    .fn          (dec_fn),
    .is_multi    (dec_multi),
    .is_div      (dec_div)
  );

  // started keeps in_ready low until the first clock after reset release.
  assign in_ready = started && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      started   <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      alu_fn    <= '0;
      is_multi  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      started <= 1'b1;
      if (flush) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_HOLD: begin
            if (accept) begin
              alu_fn   <= FN_W'(dec_fn);
              is_multi <= dec_multi;
              if (dec_multi) begin
                state     <= ST_MULTI;
                busy      <= 1'b1;
                out_valid <= 1'b0;
                cnt       <= dec_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
              end else begin
                state     <= ST_HOLD;
                out_valid <= 1'b1;
              end
            end else if ((state == ST_HOLD) && out_ready) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
            end
          end
          ST_MULTI: begin
            if (cnt == '0) begin
              state     <= ST_HOLD;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_control.sv
// Directed bench for alu_exec_control: driver task pushes expected results, a negedge monitor
// pops and compares them (function code, is_multi and first out_valid cycle).
module tb_alu_exec_control;

  localparam int FN_W  = 6;
  localparam int OP_W  = 3;
  localparam int EXP_W = 39;  // {fn[5:0], is_multi, first_valid_cycle[31:0]}

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     instruction = '0;
  logic [OP_W-1:0] alu_op = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [FN_W-1:0] alu_fn;
  logic            is_multi;
  logic            busy;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int item_start = -1;

  alu_exec_control #(.FN_W(FN_W), .OP_W(OP_W), .MUL_LAT(2), .DIV_LAT(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .alu_op      (alu_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_fn      (alu_fn),
    .is_multi    (is_multi),
    .busy        (busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: offer one op starting at posedge+1, return at posedge+1 after the accept edge
  task automatic send(input logic [31:0] ins, input logic [2:0] op, input logic [5:0] efn,
                      input logic emul, input int lat, input bit push, output int acc);
    instruction = ins;
    alu_op      = op;
    in_valid    = 1'b1;
    acc         = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("send_timeout", 0, 1);
    else if (push) exp_q.push_back({efn, emul, 32'(acc + lat)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk("drain_timeout", int'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && item_start < 0) item_start = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mon_alu_fn", int'(alu_fn), int'(mon_e[38:33]));
          chk("mon_is_multi", int'(is_multi), int'(mon_e[32]));
          chk("mon_first_valid_cycle", item_start, int'(mon_e[31:0]));
        end
        item_start = -1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stim
    int a0, a1, a2, rise, seen;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_alu_fn", int'(alu_fn), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    #2 rst_n = 1'b1;
    #1 chk("rst_release_in_ready_low", int'(in_ready), 0);
    @(posedge clk);
    #1 chk("rst_release_in_ready_high", int'(in_ready), 1);

    // SLT via alu_op, instruction bits ignored
    send(32'h4000_5033, 3'b110, 6'h0B, 1'b0, 1, 1'b1, a0);
    drain();

    // back-to-back R-type ADD / SUB / SRA
    send(32'h0000_0033, 3'b010, 6'd0, 1'b0, 1, 1'b1, a0);
    send(32'h4000_0033, 3'b010, 6'd1, 1'b0, 1, 1'b1, a1);
    send(32'h4000_5033, 3'b010, 6'd8, 1'b0, 1, 1'b1, a2);
    chk("b2b_accept_1", a1, a0 + 1);
    chk("b2b_accept_2", a2, a1 + 1);
    drain();

    // more decode vectors
    send(32'h0000_0000, 3'b001, 6'd1, 1'b0, 1, 1'b1, a0);
    send(32'h0000_0000, 3'b011, 6'd2, 1'b0, 1, 1'b1, a0);
    send(32'h0000_0000, 3'b100, 6'd4, 1'b0, 1, 1'b1, a0);
    send(32'h0000_1033, 3'b010, 6'd3, 1'b0, 1, 1'b1, a0);
    send(32'h0000_3033, 3'b010, 6'd5, 1'b0, 1, 1'b1, a0);
    send(32'h0000_5033, 3'b010, 6'd7, 1'b0, 1, 1'b1, a0);
    send(32'h0000_7033, 3'b010, 6'd2, 1'b0, 1, 1'b1, a0);
    send(32'h4000_1033, 3'b010, 6'd0, 1'b0, 1, 1'b1, a0);
    send(32'h4000_0033, 3'b111, 6'd0, 1'b0, 1, 1'b1, a0);
    drain();

    // MUL: busy for 2 cycles, out_valid at accept+3
    send(32'h0200_0033, 3'b111, 6'd16, 1'b1, 3, 1'b1, a0);
    @(negedge clk);
    chk("mul_busy_c1", int'(busy), 1);
    chk("mul_in_ready_c1", int'(in_ready), 0);
    chk("mul_out_valid_c1", int'(out_valid), 0);
    @(negedge clk);
    chk("mul_busy_c2", int'(busy), 1);
    chk("mul_in_ready_c2", int'(in_ready), 0);
    @(negedge clk);
    chk("mul_busy_c3", int'(busy), 0);
    drain();

    send(32'h0200_1033, 3'b111, 6'd17, 1'b1, 3, 1'b1, a0);
    send(32'h0200_4033, 3'b111, 6'd20, 1'b1, 33, 1'b1, a0);
    drain();
    send(32'h0200_7033, 3'b111, 6'd23, 1'b1, 33, 1'b1, a0);
    drain();

    // backpressure: XOR held 5 cycles, OR offered meanwhile, accepted when out_ready rises
    out_ready = 1'b0;
    send(32'h0000_0000, 3'b101, 6'd6, 1'b0, 1, 1'b1, a0);
    instruction = 32'h0;
    alu_op      = 3'b100;
    in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_alu_fn_stable", int'(alu_fn), 6);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    rise = cyc;
    send(32'h0000_0000, 3'b100, 6'd4, 1'b0, 1, 1'b1, a1);
    chk("bp_accept_same_cycle", a1, rise);
    drain();

    // flush at MULTI cycle 10 of a DIV: no result, then normal ADD
    send(32'h0200_4033, 3'b111, 6'd20, 1'b1, 33, 1'b0, a0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_in_ready", int'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("flush_no_out_valid", seen, 0);
    @(posedge clk);
    #1;
    send(32'h0000_0000, 3'b000, 6'd0, 1'b0, 1, 1'b1, a0);
    drain();

    // flush overrides a same-cycle in_valid in IDLE
    alu_op   = 3'b001;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_blocks_accept", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // reset in the middle of a MUL
    send(32'h0200_0033, 3'b111, 6'd16, 1'b1, 3, 1'b1, a0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_alu_fn", int'(alu_fn), 0);
    chk("mrst_is_multi", int'(is_multi), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_in_ready", int'(in_ready), 0);
    exp_q.delete();
    item_start = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mrst_in_ready_held", int'(in_ready), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("mrst_in_ready_after", int'(in_ready), 1);
    send(32'h0000_0000, 3'b101, 6'd6, 1'b0, 1, 1'b1, a0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
